fx2_slave_fifo: RTL and testbench
=================================

FX2_SLAVE_FIFO -- requirements
Module: fx2_slave_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning word capacity of each of the EP2 (OUT) and EP6 (IN) FIFOs; it SHALL be a power of 2.
REQ-002 SHALL have parameter PKT_WORDS, default 256, meaning the EP6 auto-commit packet size in 16-bit words.
REQ-003 SHALL have parameter PF_LEVEL, default 256, meaning the EP2 programmable-flag threshold in words.
REQ-004 ifclk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 fx2_flags  out  3  [0] EP2 not-empty, [1] EP6 not-full, [2] EP2 count >= PF_LEVEL.
REQ-007 fx2_sloe_b  in  1  active-low output enable for fx2_fd.
REQ-008 fx2_slrd_b  in  1  active-low read strobe.
REQ-009 fx2_slwr_b  in  1  active-low write strobe.
REQ-010 fx2_pktend_b  in  1  active-low packet-end strobe.
REQ-011 fx2_fifo_addr  in  2  2'b00 selects EP2, 2'b10 selects EP6; 2'b01 and 2'b11 are unmapped.
REQ-012 fx2_fd  inout  16  slave FIFO data bus.
REQ-013 host_out_data / host_out_valid / host_out_ready  in 16 / in 1 / out 1  host-to-EP2 push port, valid/ready.
REQ-014 host_in_data / host_in_last / host_in_valid / host_in_ready  out 16 / out 1 / out 1 / in 1  EP6-to-host pop port, valid/ready; last marks the final word of a committed packet.
REQ-015 err_underflow, err_overflow, err_badaddr  out  1 each  sticky error flags.

Function
REQ-016 fx2_fd SHALL be driven with the EP2 head word exactly when fx2_sloe_b=0 and fx2_fifo_addr=00, and SHALL be high-Z otherwise; the head word is first-word-fall-through, with no read latency.
REQ-017 fx2_sloe_b=0 with any other address SHALL drive 16'h0000.
REQ-018 A clock edge with fx2_slrd_b=0, address 00, and EP2 not empty SHALL pop one word; with EP2 empty it SHALL pop nothing and set err_underflow.
REQ-019 A clock edge with fx2_slwr_b=0 and address 10 SHALL push the sampled fx2_fd into EP6 if EP6 is not full; if EP6 is full it SHALL drop the word and set err_overflow.
REQ-020 slrd/slwr/pktend asserted with address 01 or 11 SHALL have no FIFO effect and SHALL set err_badaddr.
REQ-021 Pushed EP6 words SHALL be invisible to the host until committed; the uncommitted count increments per push.
REQ-022 When the uncommitted count reaches PKT_WORDS, the packet SHALL be committed on the same edge as the completing push.
REQ-023 fx2_pktend_b=0 at address 10 SHALL commit all uncommitted words, including a word written on the same edge.
REQ-024 pktend with zero uncommitted words SHALL be ignored (no zero-length packet).
REQ-025 The block SHALL hold a queue of committed packet end-pointers (depth DEPTH/ 1 min 16); host_in_last SHALL be 1 on the word at the head end-pointer.
REQ-026 host_in_valid SHALL be 1 iff committed words > 0; a word SHALL be popped on host_in_valid & host_in_ready.
REQ-027 host_out_ready SHALL be 1 iff EP2 is not full; a push SHALL occur on host_out_valid & host_out_ready.
REQ-028 A simultaneous EP2 host push and FX2 pop SHALL both occur, leaving the count unchanged; the same applies to EP6.
REQ-029 fx2_flags SHALL be combinational from the registered counts, so each reflects state the cycle after the causing edge.
REQ-030 Flag definitions: [1] SHALL be 0 when EP6 total words (committed + uncommitted) = DEPTH.
REQ-031 Pointers SHALL wrap modulo DEPTH; the counts SHALL be $clog2(DEPTH)+1 bits wide.

Reset
REQ-032 On reset, the following SHALL hold on the next edge regardless of in-progress strobes: both FIFOs empty, commit queue empty, fx2_flags=3'b010, host_in_valid=0, host_in_last=0, host_out_ready=1, and all err flags 0.
REQ-033 Error flags SHALL clear only on reset.

Verification
REQ-034 Host pushes 0x1000..0x1003, then slrd strobes 4 edges at address 00 with sloe_b=0 -> fd shows 0x1000,0x1001,0x1002,0x1003 in order, then fx2_flags[0]=0.
REQ-035 slwr strobes 255 words to EP6 -> host_in_valid stays 0; the 256th word -> host_in_valid=1, and host_in_last=1 only on the 256th popped word.
REQ-036 3 slwr words, then pktend together with a 4th slwr -> host receives 4 words with last on the 4th; a following pktend alone produces no packet.
REQ-037 EP6 filled to 512 with the host stalled -> fx2_flags[1]=0; a 513th slwr is dropped and err_overflow=1.
REQ-038 slrd with EP2 empty -> err_underflow=1 and the count remains 0; slwr at address 01 -> err_badaddr=1.
REQ-039 reset asserted mid-packet (100 uncommitted words) -> next cycle fx2_flags=3'b010, host_in_valid=0, and a later pktend yields no packet.

Source files
------------

// File: rtl/fx2_slave_fifo_if.sv
// Host-side streaming ports of the FX2 slave FIFO bridge.
// out_*: host pushes into EP2; in_*: host pops committed EP6 packets.
interface fx2_slave_fifo_if;
  logic [15:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic [15:0] host_in_data;
  logic        host_in_last;
  logic        host_in_valid;
  logic        host_in_ready;

  modport master (
    output host_out_data,
    output host_out_valid,
    input  host_out_ready,
    input  host_in_data,
    input  host_in_last,
    input  host_in_valid,
    output host_in_ready
  );

  modport slave (
    input  host_out_data,
    input  host_out_valid,
    output host_out_ready,
    output host_in_data,
    output host_in_last,
    output host_in_valid,
    input  host_in_ready
  );
endinterface

// File: rtl/fx2_slave_fifo.sv
// FX2 slave-FIFO bridge: EP2 (host->FX2, FWFT on fx2_fd) and EP6
// (FX2->host, packetised). Ports: ifclk/reset, FX2 strobes, flags,
// fx2_fd bus, host interface (slave modport), sticky error flags.
module fx2_slave_fifo #(
  parameter int DEPTH     = 512,
  parameter int PKT_WORDS = 256,
  parameter int PF_LEVEL  = 256
) (
  input  logic        ifclk,
  input  logic        reset,
  output logic [2:0]  fx2_flags,
  input  logic        fx2_sloe_b,
  input  logic        fx2_slrd_b,
  input  logic        fx2_slwr_b,
  input  logic        fx2_pktend_b,
  input  logic [1:0]  fx2_fifo_addr,
  inout  wire  [15:0] fx2_fd,
  fx2_slave_fifo_if.slave host,
  output logic        err_underflow,
  output logic        err_overflow,
  output logic        err_badaddr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int CQ_DEPTH = (DEPTH < 16) ? 16 : DEPTH;
  localparam int QW = $clog2(CQ_DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] PKT_C  = CW'(PKT_WORDS);
  localparam logic [CW-1:0] PF_C   = CW'(PF_LEVEL);

  // storage
  logic [15:0]   ep2_mem_q [DEPTH];
  logic [15:0]   ep6_mem_q [DEPTH];
  logic [AW-1:0] cq_mem_q  [CQ_DEPTH];

  // EP2 state
  logic [AW-1:0] ep2_wr_q, ep2_wr_d;
  logic [AW-1:0] ep2_rd_q, ep2_rd_d;
  logic [CW-1:0] ep2_cnt_q, ep2_cnt_d;

  // EP6 state: cnt is total, unc is the uncommitted tail
  logic [AW-1:0] ep6_wr_q, ep6_wr_d;
  logic [AW-1:0] ep6_rd_q, ep6_rd_d;
  logic [CW-1:0] ep6_cnt_q, ep6_cnt_d;
  logic [CW-1:0] ep6_unc_q, ep6_unc_d;

  // commit queue of packet end pointers
  logic [QW-1:0] cq_wr_q, cq_wr_d;
  logic [QW-1:0] cq_rd_q, cq_rd_d;
  logic [QW:0]   cq_cnt_q, cq_cnt_d;

  logic uf_q, uf_d;
  logic of_q, of_d;
  logic ba_q, ba_d;

  // decode
  logic sel_ep2, sel_ep6, sel_bad;
  logic rd_stb, wr_stb, pe_stb;
  logic ep2_full, ep2_empty, ep6_full;
  logic ep2_push, ep2_pop;
  logic ep6_push, ep6_pop;
  logic [CW-1:0] ep6_cmt;
  logic [CW-1:0] unc_inc;
  logic commit;
  logic head_last;
  logic cq_pop;
  logic [AW-1:0] end_ptr;
  logic [15:0] fd_out;
  logic fd_oe;

  always_comb begin
    sel_ep2 = (fx2_fifo_addr == 2'b00);
    sel_ep6 = (fx2_fifo_addr == 2'b10);
    sel_bad = fx2_fifo_addr[0];
    rd_stb  = ~fx2_slrd_b;
    wr_stb  = ~fx2_slwr_b;
    pe_stb  = ~fx2_pktend_b;

    ep2_full  = (ep2_cnt_q == FULL_C);
    ep2_empty = (ep2_cnt_q == '0);
    ep6_full  = (ep6_cnt_q == FULL_C);

    ep2_push = host.host_out_valid & ~ep2_full;
    ep2_pop  = rd_stb & sel_ep2 & ~ep2_empty;

    ep6_cmt  = ep6_cnt_q - ep6_unc_q;
    ep6_push = wr_stb & sel_ep6 & ~ep6_full;
    ep6_pop  = host.host_in_valid & host.host_in_ready;

    // a pktend on the same edge as a write commits that word too
    unc_inc = ep6_unc_q + CW'(ep6_push);
    commit  = (ep6_push && (unc_inc == PKT_C))
            || (pe_stb && sel_ep6 && (unc_inc != '0));

    // head packet ends when the read pointer hits its end pointer
    head_last = (cq_cnt_q != '0) && (ep6_rd_q == cq_mem_q[cq_rd_q]);
    cq_pop    = ep6_pop & head_last;

    ep2_wr_d  = ep2_wr_q + AW'(ep2_push);
    ep2_rd_d  = ep2_rd_q + AW'(ep2_pop);
    ep2_cnt_d = ep2_cnt_q + CW'(ep2_push) - CW'(ep2_pop);

    ep6_wr_d  = ep6_wr_q + AW'(ep6_push);
    ep6_rd_d  = ep6_rd_q + AW'(ep6_pop);
    ep6_cnt_d = ep6_cnt_q + CW'(ep6_push) - CW'(ep6_pop);
    ep6_unc_d = commit ? '0 : unc_inc;
    end_ptr   = ep6_wr_d - AW'(1);

    cq_wr_d  = cq_wr_q + QW'(commit);
    cq_rd_d  = cq_rd_q + QW'(cq_pop);
    cq_cnt_d = cq_cnt_q + (QW+1)'(commit) - (QW+1)'(cq_pop);

    uf_d = uf_q | (rd_stb & sel_ep2 & ep2_empty);
    of_d = of_q | (wr_stb & sel_ep6 & ep6_full);
    ba_d = ba_q | ((rd_stb | wr_stb | pe_stb) & sel_bad);
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      ep2_wr_q  <= '0;
      ep2_rd_q  <= '0;
      ep2_cnt_q <= '0;
      ep6_wr_q  <= '0;
      ep6_rd_q  <= '0;
      ep6_cnt_q <= '0;
      ep6_unc_q <= '0;
      cq_wr_q   <= '0;
      cq_rd_q   <= '0;
      cq_cnt_q  <= '0;
      uf_q      <= 1'b0;
      of_q      <= 1'b0;
      ba_q      <= 1'b0;
    end else begin
      ep2_wr_q  <= ep2_wr_d;
      ep2_rd_q  <= ep2_rd_d;
      ep2_cnt_q <= ep2_cnt_d;
      ep6_wr_q  <= ep6_wr_d;
      ep6_rd_q  <= ep6_rd_d;
      ep6_cnt_q <= ep6_cnt_d;
      ep6_unc_q <= ep6_unc_d;
      cq_wr_q   <= cq_wr_d;
      cq_rd_q   <= cq_rd_d;
      cq_cnt_q  <= cq_cnt_d;
      uf_q      <= uf_d;
      of_q      <= of_d;
      ba_q      <= ba_d;
    end
  end

  // data arrays need no reset; validity is tracked by the counts
  always_ff @(posedge ifclk) begin
    if (!reset && ep2_push)
      ep2_mem_q[ep2_wr_q] <= host.host_out_data;
    if (!reset && ep6_push)
      ep6_mem_q[ep6_wr_q] <= fx2_fd;
    if (!reset && commit)
      cq_mem_q[cq_wr_q] <= end_ptr;
  end

  always_comb begin
    fd_oe  = ~fx2_sloe_b;
    fd_out = sel_ep2 ? ep2_mem_q[ep2_rd_q] : 16'h0000;
  end

  assign fx2_fd = fd_oe ? fd_out : 16'bz;

  assign fx2_flags[0] = ~ep2_empty;
  assign fx2_flags[1] = ~ep6_full;
  assign fx2_flags[2] = (ep2_cnt_q >= PF_C);

  assign host.host_out_ready = ~ep2_full;
  assign host.host_in_valid  = (ep6_cmt != '0);
  assign host.host_in_data   = ep6_mem_q[ep6_rd_q];
  assign host.host_in_last   = host.host_in_valid & head_last;

  assign err_underflow = uf_q;
  assign err_overflow  = of_q;
  assign err_badaddr   = ba_q;

endmodule

// File: tb/tb_fx2_slave_fifo.sv
// Self-checking bench for fx2_slave_fifo.
// Scoreboard queues hold expected EP2 fd words and EP6 {last,data}.
module tb_fx2_slave_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  flags;
  logic        sloe_b, slrd_b, slwr_b, pktend_b;
  logic [1:0]  addr;
  wire  [15:0] fd;
  logic        fd_oe;
  logic [15:0] fd_drv;
  logic        e_uf, e_of, e_ba;

  assign fd = fd_oe ? fd_drv : 16'bz;

  fx2_slave_fifo_if hif();

  fx2_slave_fifo dut (
    .ifclk(clk),
    .reset(reset),
    .fx2_flags(flags),
    .fx2_sloe_b(sloe_b),
    .fx2_slrd_b(slrd_b),
    .fx2_slwr_b(slwr_b),
    .fx2_pktend_b(pktend_b),
    .fx2_fifo_addr(addr),
    .fx2_fd(fd),
    .host(hif),
    .err_underflow(e_uf),
    .err_overflow(e_of),
    .err_badaddr(e_ba)
  );

  logic [15:0] sb2[$];
  logic [16:0] sb6[$];
  int m_unc;
  int m_tot;
  int n_chk;
  int n_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark_last();
    int k;
    logic [16:0] t;
    k = sb6.size() - 1;
    t = sb6[k];
    t[16] = 1'b1;
    sb6[k] = t;
    m_unc = 0;
  endtask

  task automatic host_push(input logic [15:0] d);
    chk("out_ready", {31'b0, hif.host_out_ready}, 32'd1);
    hif.host_out_data  = d;
    hif.host_out_valid = 1'b1;
    tick();
    hif.host_out_valid = 1'b0;
    sb2.push_back(d);
  endtask

  task automatic fx2_rd_chk();
    addr   = 2'b00;
    sloe_b = 1'b0;
    #1;
    chk("fd_word", {16'b0, fd}, {16'b0, sb2.pop_front()});
    slrd_b = 1'b0;
    tick();
    slrd_b = 1'b1;
  endtask

  task automatic fx2_wr(input logic [15:0] d, input bit pe);
    addr     = 2'b10;
    fd_drv   = d;
    fd_oe    = 1'b1;
    slwr_b   = 1'b0;
    pktend_b = ~pe;
    tick();
    slwr_b   = 1'b1;
    pktend_b = 1'b1;
    fd_oe    = 1'b0;
    if (m_tot < 512) begin
      sb6.push_back({1'b0, d});
      m_tot++;
      m_unc++;
    end
    if (m_unc > 0 && (m_unc == 256 || pe))
      mark_last();
  endtask

  task automatic fx2_pktend();
    addr     = 2'b10;
    pktend_b = 1'b0;
    tick();
    pktend_b = 1'b1;
    if (m_unc > 0)
      mark_last();
  endtask

  task automatic drain6();
    int budget;
    logic [16:0] e;
    budget = 4000;
    hif.host_in_ready = 1'b1;
    while (sb6.size() > 0 && budget > 0) begin
      if (hif.host_in_valid) begin
        e = sb6.pop_front();
        chk("in_word", {15'b0, hif.host_in_last, hif.host_in_data},
            {15'b0, e});
        m_tot--;
      end
      tick();
      budget--;
    end
    hif.host_in_ready = 1'b0;
    if (sb6.size() > 0)
      chk("drain_timeout", sb6.size(), 0);
    chk("in_idle", {31'b0, hif.host_in_valid}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    m_unc = 0;
    m_tot = 0;
    reset = 1'b1;
    sloe_b = 1'b1;
    slrd_b = 1'b1;
    slwr_b = 1'b1;
    pktend_b = 1'b1;
    addr = 2'b00;
    fd_oe = 1'b0;
    fd_drv = '0;
    hif.host_out_data = '0;
    hif.host_out_valid = 1'b0;
    hif.host_in_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_flags", {29'b0, flags}, 32'd2);
    chk("rst_in_valid", {31'b0, hif.host_in_valid}, 32'd0);
    chk("rst_in_last", {31'b0, hif.host_in_last}, 32'd0);
    chk("rst_out_ready", {31'b0, hif.host_out_ready}, 32'd1);
    chk("rst_errs", {29'b0, e_uf, e_of, e_ba}, 32'd0);

    // EP2 ordered FWFT readout
    for (int i = 0; i < 4; i++)
      host_push(16'h1000 + 16'(i));
    chk("ep2_ne", {31'b0, flags[0]}, 32'd1);
    for (int i = 0; i < 4; i++)
      fx2_rd_chk();
    sloe_b = 1'b1;
    chk("ep2_drained", {31'b0, flags[0]}, 32'd0);

    // simultaneous host push and FX2 pop on EP2
    host_push(16'h2000);
    hif.host_out_data  = 16'h2001;
    hif.host_out_valid = 1'b1;
    addr   = 2'b00;
    sloe_b = 1'b0;
    slrd_b = 1'b0;
    #1;
    chk("sim_fd", {16'b0, fd}, {16'b0, sb2.pop_front()});
    tick();
    hif.host_out_valid = 1'b0;
    slrd_b = 1'b1;
    sb2.push_back(16'h2001);
    chk("sim_ne", {31'b0, flags[0]}, 32'd1);
    fx2_rd_chk();
    sloe_b = 1'b1;
    chk("sim_empty", {31'b0, flags[0]}, 32'd0);

    // programmable flag threshold
    for (int i = 0; i < 255; i++)
      host_push(16'h3000 + 16'(i));
    chk("pf_below", {31'b0, flags[2]}, 32'd0);
    host_push(16'h30ff);
    chk("pf_at", {31'b0, flags[2]}, 32'd1);
    while (sb2.size() > 0)
      fx2_rd_chk();
    sloe_b = 1'b1;
    chk("pf_clear", {31'b0, flags[2]}, 32'd0);

    // EP6 auto-commit at PKT_WORDS
    for (int i = 0; i < 255; i++)
      fx2_wr(16'h4000 + 16'(i), 1'b0);
    chk("unc_hidden", {31'b0, hif.host_in_valid}, 32'd0);
    fx2_wr(16'h40ff, 1'b0);
    chk("auto_commit", {31'b0, hif.host_in_valid}, 32'd1);
    drain6();

    // pktend with a same-edge write, then empty pktend
    for (int i = 0; i < 3; i++)
      fx2_wr(16'h5000 + 16'(i), 1'b0);
    fx2_wr(16'h5003, 1'b1);
    drain6();
    fx2_pktend();
    tick();
    tick();
    chk("zlp_ignored", {31'b0, hif.host_in_valid}, 32'd0);

    // EP6 full and overflow
    for (int i = 0; i < 511; i++)
      fx2_wr(16'h6000 + 16'(i), 1'b0);
    chk("ep6_nf_511", {31'b0, flags[1]}, 32'd1);
    fx2_wr(16'h61ff, 1'b0);
    chk("ep6_full", {31'b0, flags[1]}, 32'd0);
    chk("of_before", {31'b0, e_of}, 32'd0);
    fx2_wr(16'hdead, 1'b0);
    chk("of_set", {31'b0, e_of}, 32'd1);
    chk("ep6_still_full", {31'b0, flags[1]}, 32'd0);
    drain6();
    chk("ep6_nf_again", {31'b0, flags[1]}, 32'd1);

    // underflow, unmapped addresses
    chk("uf_before", {31'b0, e_uf}, 32'd0);
    addr   = 2'b00;
    slrd_b = 1'b0;
    tick();
    slrd_b = 1'b1;
    chk("uf_set", {31'b0, e_uf}, 32'd1);
    chk("uf_cnt0", {31'b0, flags[0]}, 32'd0);
    addr   = 2'b01;
    sloe_b = 1'b0;
    #1;
    chk("fd_unmapped", {16'b0, fd}, 32'd0);
    sloe_b = 1'b1;
    chk("ba_before", {31'b0, e_ba}, 32'd0);
    slwr_b = 1'b0;
    tick();
    slwr_b = 1'b1;
    chk("ba_set", {31'b0, e_ba}, 32'd1);
    chk("ba_no_ep6", {31'b0, hif.host_in_valid}, 32'd0);

    // reset mid-packet with a write in flight
    for (int i = 0; i < 100; i++)
      fx2_wr(16'h7000 + 16'(i), 1'b0);
    chk("mid_hidden", {31'b0, hif.host_in_valid}, 32'd0);
    addr   = 2'b10;
    fd_drv = 16'h7fff;
    fd_oe  = 1'b1;
    slwr_b = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    slwr_b = 1'b1;
    fd_oe  = 1'b0;
    sb6.delete();
    m_unc = 0;
    m_tot = 0;
    chk("mid_rst_flags", {29'b0, flags}, 32'd2);
    chk("mid_rst_valid", {31'b0, hif.host_in_valid}, 32'd0);
    chk("mid_rst_errs", {29'b0, e_uf, e_of, e_ba}, 32'd0);
    fx2_pktend();
    tick();
    tick();
    chk("mid_rst_zlp", {31'b0, hif.host_in_valid}, 32'd0);
    chk("mid_rst_last", {31'b0, hif.host_in_last}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
